operand_join: RTL and testbench
===============================

# operand_join

Operand join-and-hold stage directly upstream of the floating-point compute unit in each overlay tile. Buffers operand tokens arriving independently on the two input channels, pairs them in order, and presents a matched pair to the compute unit with valid bits set. Holds the pair stable until the unit's `done` pulse, then drops valid for one cycle so the unit's latency counter restarts cleanly.

## Interface
- `DEPTH`, 4: entries per channel FIFO; power of two, ≥2.
- `TIMEOUT`, 15: max cycles in ISSUE before a watchdog abort; used only with `OPJOIN_WATCHDOG_EN`.

- `clk`  in  1  tile clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_c0`  in  `PATH_WIDTH`+1  channel-0 token; bit 0 = valid, bits [`PATH_WIDTH`:1] = payload (bit 1 = routing flag, [`PATH_WIDTH`:`META_BITS`] = FP operand).
- `in_c1`  in  `PATH_WIDTH`+1  channel-1 token, same format.
- `rdy_c0`  out  1  channel-0 FIFO can accept.
- `rdy_c1`  out  1  channel-1 FIFO can accept.
- `done`  in  1  compute-unit completion for the held pair.
- `op_c0`  out  `PATH_WIDTH`+1  to compute unit `d_in_c0`; bit 0 = pair valid, [`PATH_WIDTH`:1] = channel-0 head payload.
- `op_c1`  out  `PATH_WIDTH`+1  to compute unit `d_in_c1`, same format.
- `busy`  out  1  FSM not in IDLE.
- `err`  out  1  sticky watchdog abort flag.

## Operation
- Per channel: circular FIFO, DEPTH × `PATH_WIDTH` bits, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter of log2(DEPTH)+1 bits.
- `rdy_cX` = registered occupancy < DEPTH. Push when `in_cX[0] & rdy_cX`; stores `in_cX[PATH_WIDTH:1]`.
- Full FIFO: `rdy_cX`=0 even on a pop cycle (no push-through); the token is refused and upstream holds it.
- Push and pop in the same cycle on a non-full FIFO: occupancy unchanged, both pointers advance.
- FSM states:
  - IDLE: both occupancies ≥1 → ISSUE; otherwise stay.
  - ISSUE: `op_c0[0]`=`op_c1[0]`=1, payloads = FIFO heads, stable for the whole state. `done`=1 → pop both heads, → GAP.
  - GAP: valid bits 0 for exactly one cycle, → IDLE.
- Outside ISSUE, `op_cX[0]`=0; payload bits still show the current heads (or the stale RAM word when empty, don't-care).
- `done` outside ISSUE is ignored.
- Pairing is strictly FIFO order per channel; tokens are never reordered or dropped except by watchdog abort.
- Reset, at any time including mid-ISSUE: pointers and occupancies 0, FSM IDLE, in-flight pair discarded. The compute unit's counter clears because `op_cX[0]` falls.

## Timing
- Reset values: `op_c0`=`op_c1`=0, `rdy_c0`=`rdy_c1`=1, `busy`=0, `err`=0.
- Both channels pushed at edge k with both FIFOs empty: FSM enters ISSUE at edge k+1; `op_cX[0]`=1 from edge k+1.
- `done` sampled high at edge m: valid drops at edge m, GAP during [m, m+1), IDLE at m+1, next ISSUE at edge m+2 at the earliest.
- Pair throughput: compute latency + 2 cycles of join overhead (IDLE and GAP).
- `rdy_cX` rises the cycle after the pop edge that leaves a FIFO with a free entry.
- All outputs are registered or derived only from registered state; no combinational path from `in_cX`/`done` to outputs.

## Configuration
- `OPJOIN_WATCHDOG_EN` defined: a cycle counter clears on ISSUE entry and increments in ISSUE. If it reaches TIMEOUT without `done`, pop both heads, set `err` (sticky until `rst`), and → GAP.
- Undefined: no counter; ISSUE waits indefinitely for `done`; `err` tied to 0.

## Test plan
- Reset → `op_c0`=`op_c1`=0, `rdy_cX`=1, `busy`=0. Push c0=0x3F800000 and c1=0x40000000 at the same edge → valid rises one edge later with those payloads; `done` 6 cycles later → valid falls, one GAP cycle, IDLE.
- Skewed arrival: c0 token at edge 0, c1 token at edge 5 → valid stays 0 until edge 6; pair held stable through `done`.
- Back-pressure: push 5 tokens into c0 with c1 idle (DEPTH=4) → `rdy_c0`=0 after the 4th push, 5th refused. Then feed 4 c1 tokens and pulse `done` ×4 → pairs emerge in push order, `rdy_c0` returns to 1.
- Pointer wrap: stream 10 paired tokens, values 1..10, through DEPTH=4 → pairs (1,1)…(10,10) in order, no loss.
- Reset asserted mid-ISSUE → valid drops immediately, FIFOs empty, and a post-reset pair issues normally.
- With `OPJOIN_WATCHDOG_EN`, TIMEOUT=15: issue a pair, never assert `done` → abort after 15 ISSUE cycles, `err`=1 held until `rst`, next pair issues.

Source files
------------

// File: rtl/operand_join.sv
// operand_join: pairs operand tokens from two independent channels and holds
// each pair stable for the floating-point compute unit until it pulses done.
//
// Ports
//   clk, rst   tile clock, asynchronous active-high reset
//   in_c0/1    input token {payload[PATH_WIDTH:1], valid[0]}
//   rdy_c0/1   channel FIFO can accept a token
//   done       compute-unit completion for the held pair
//   op_c0/1    {head payload, pair valid} to the compute unit
//   busy       FSM not idle
//   err        sticky watchdog abort flag
//
// Optional feature: define OPJOIN_WATCHDOG_EN to abort a pair that waits
// TIMEOUT cycles in ISSUE without done (both heads dropped, err set).
module operand_join #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned PATH_WIDTH = 33,
    parameter int unsigned META_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PATH_WIDTH:0]   in_c0,
    input  logic [PATH_WIDTH:0]   in_c1,
    output logic                  rdy_c0,
    output logic                  rdy_c1,
    input  logic                  done,
    output logic [PATH_WIDTH:0]   op_c0,
    output logic [PATH_WIDTH:0]   op_c1,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("operand_join: DEPTH must be a power of two >= 2");
    end
    if ((META_BITS < 2) || (META_BITS > PATH_WIDTH)) begin : g_bad_meta
        $error("operand_join: META_BITS out of range");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("operand_join: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  pop_w;
    logic                  abort_w;
    logic [PATH_WIDTH:0]   in_w   [2];
    logic [PATH_WIDTH-1:0] head_w [2];
    logic [CW-1:0]         occ_w  [2];
    logic                  rdy_w  [2];

    assign in_w[0] = in_c0;
    assign in_w[1] = in_c1;

    // Per-channel circular FIFO
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [PATH_WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0]         cnt_q, cnt_d;
        logic                  push;

        // No push-through: a full FIFO refuses even on a pop cycle
        assign rdy_w[ch]  = (cnt_q < CW'(DEPTH));
        assign push       = in_w[ch][0] & rdy_w[ch];
        assign occ_w[ch]  = cnt_q;
        assign head_w[ch] = mem_q[rd_q];

        always_comb begin
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (push) begin
                wr_d = wr_q + AW'(1);
            end
            if (pop_w) begin
                rd_d = rd_q + AW'(1);
            end
            if (push && !pop_w) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!push && pop_w) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
        end

        // Storage needs no reset; occupancy gates every use
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_q] <= in_w[ch][PATH_WIDTH:1];
            end
        end
    end

`ifdef OPJOIN_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    // Cleared while idle so it starts from zero on every ISSUE entry
    always_comb begin
        wd_d    = wd_q;
        abort_w = 1'b0;
        if (state_q == S_IDLE) begin
            wd_d = '0;
        end else if ((state_q == S_ISSUE) && !done) begin
            if (wd_q == WDW'(TIMEOUT - 1)) begin
                abort_w = 1'b1;
            end else begin
                wd_d = wd_q + WDW'(1);
            end
        end
        err_d = err_q | abort_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign abort_w = 1'b0;
    assign err     = 1'b0;
`endif

    // Join FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Join FSM: next state and pop
    always_comb begin
        state_d = state_q;
        pop_w   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((occ_w[0] != '0) && (occ_w[1] != '0)) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (done || abort_w) begin
                    pop_w   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state
    assign op_c0  = {head_w[0], (state_q == S_ISSUE)};
    assign op_c1  = {head_w[1], (state_q == S_ISSUE)};
    assign rdy_c0 = rdy_w[0];
    assign rdy_c1 = rdy_w[1];
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_operand_join.sv
module tb_operand_join;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned PW      = 33;
    localparam int unsigned MB      = 2;

    typedef logic [PW-1:0] pl_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW:0]   in_c0, in_c1, op_c0, op_c1;
    logic          rdy_c0, rdy_c1, done, busy, err;

    always #5 clk = ~clk;

    operand_join #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .PATH_WIDTH(PW), .META_BITS(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .in_c0(in_c0), .in_c1(in_c1),
        .rdy_c0(rdy_c0), .rdy_c1(rdy_c1),
        .done(done),
        .op_c0(op_c0), .op_c1(op_c1),
        .busy(busy), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-channel token queues plus the join phase
    pl_t q0[$], q1[$];
    pl_t src0[$], src1[$];
    int  mphase;    // 0 waiting for a pair, 1 pair offered, 2 gap cycle
    int  icnt;
    bit  merr;
    bit  a0, a1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic pl_t mk(input logic [31:0] fp, input bit flag);
        return {fp, flag};
    endfunction

    task automatic compare_outputs();
        check("valid0", 64'(op_c0[0]), 64'(mphase == 1));
        check("valid1", 64'(op_c1[0]), 64'(mphase == 1));
        check("busy",   64'(busy),     64'(mphase != 0));
        check("rdy0",   64'(rdy_c0),   64'(q0.size() < DEPTH));
        check("rdy1",   64'(rdy_c1),   64'(q1.size() < DEPTH));
        check("err",    64'(err),      64'(merr));
        if (mphase == 1) begin
            check("head0", 64'(op_c0[PW:1]), 64'(q0[0]));
            check("head1", 64'(op_c1[PW:1]), 64'(q1[0]));
        end
    endtask

    // One clock with the given inputs; model advanced, outputs compared
    task automatic step(input bit v0, input pl_t p0, input bit v1, input pl_t p1,
                        input bit d, output bit acc0, output bit acc1);
        int  s0, s1;
        bit  pop, abort;
        in_c0 = {p0, v0};
        in_c1 = {p1, v1};
        done  = d;
        s0    = q0.size();
        s1    = q1.size();
        acc0  = v0 && (s0 < DEPTH);
        acc1  = v1 && (s1 < DEPTH);
        abort = 1'b0;
`ifdef OPJOIN_WATCHDOG_EN
        if ((mphase == 1) && !d) begin
            icnt++;
            if (icnt >= TIMEOUT) abort = 1'b1;
        end
`endif
        pop = (mphase == 1) && (d || abort);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (abort) merr = 1'b1;
        if (acc0) q0.push_back(p0);
        if (acc1) q1.push_back(p1);
        case (mphase)
            0: if (s0 >= 1 && s1 >= 1) begin mphase = 1; icnt = 0; end
            1: if (pop) mphase = 2;
            default: mphase = 0;
        endcase
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, a0, a1);
    endtask

    task automatic apply_reset();
        in_c0 = '0;
        in_c1 = '0;
        done  = 1'b0;
        #2 rst = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        mphase = 0;
        icnt   = 0;
        merr   = 1'b0;
        compare_outputs();
        check("rst_op0", 64'(op_c0[0]), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        compare_outputs();
    endtask

    // Stream src0/src1 with upstream holding refused tokens and random done
    task automatic stream(input int gap_pct, input int budget);
        int  cyc;
        bit  v0, v1, d;
        cyc = 0;
        while ((src0.size() != 0 || src1.size() != 0 || q0.size() != 0 ||
                q1.size() != 0 || mphase != 0) && cyc < budget) begin
            v0 = (src0.size() != 0) && ($urandom_range(0, 99) >= gap_pct);
            v1 = (src1.size() != 0) && ($urandom_range(0, 99) >= gap_pct);
            d  = (mphase == 1) && ($urandom_range(0, 3) == 0);
            step(v0, v0 ? src0[0] : pl_t'($urandom), v1, v1 ? src1[0] : pl_t'($urandom),
                 d, a0, a1);
            if (a0) void'(src0.pop_front());
            if (a1) void'(src1.pop_front());
            cyc++;
        end
        check("stream_drained", 64'(cyc < budget), 64'd1);
        src0.delete();
        src1.delete();
    endtask

    initial begin
        in_c0  = '0;
        in_c1  = '0;
        done   = 1'b0;
        mphase = 0;
        icnt   = 0;
        merr   = 1'b0;

        // Reset values
        apply_reset();
        check("rst_rdy0", 64'(rdy_c0), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);

        // Simultaneous arrival, done six cycles after issue
        step(1, mk(32'h3F800000, 1'b0), 1, mk(32'h40000000, 1'b1), 0, a0, a1);
        check("t1_not_yet", 64'(op_c0[0]), 64'd0);
        idle(1);
        check("t1_valid",  64'(op_c0[0] & op_c1[0]), 64'd1);
        check("t1_fp0",    64'(op_c0[PW:MB]), 64'h3F800000);
        check("t1_fp1",    64'(op_c1[PW:MB]), 64'h40000000);
        check("t1_flag1",  64'(op_c1[1]), 64'd1);
        idle(5);
        step(0, '0, 0, '0, 1, a0, a1);
        check("t1_gap_valid", 64'(op_c0[0]), 64'd0);
        check("t1_gap_busy",  64'(busy), 64'd1);
        idle(1);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Skewed arrival
        step(1, mk(32'h11111111, 1'b0), 0, '0, 0, a0, a1);
        idle(4);
        step(0, '0, 1, mk(32'h22222222, 1'b0), 0, a0, a1);
        check("t2_wait", 64'(op_c0[0]), 64'd0);
        idle(1);
        check("t2_valid", 64'(op_c1[0]), 64'd1);
        idle(3);
        check("t2_hold", 64'(op_c0[PW:MB]), 64'h11111111);
        step(0, '0, 0, '0, 1, a0, a1);
        idle(2);

        // Back-pressure on channel 0
        for (int i = 0; i < 5; i++) step(1, pl_t'(100 + i), 0, '0, 0, a0, a1);
        check("t3_full", 64'(rdy_c0), 64'd0);
        for (int j = 0; j < 4; j++) src1.push_back(pl_t'(200 + j));
        stream(0, 200);
        check("t3_rdy_back", 64'(rdy_c0), 64'd1);

        // Pointer wrap: ten pairs through a four-entry FIFO
        for (int k = 1; k <= 10; k++) begin
            src0.push_back(pl_t'(k));
            src1.push_back(pl_t'(k));
        end
        stream(0, 400);

        // Random traffic
        for (int k = 0; k < 25; k++) begin
            src0.push_back(pl_t'({$urandom, $urandom}));
            src1.push_back(pl_t'({$urandom, $urandom}));
        end
        stream(40, 2000);

        // Reset in the middle of an issued pair
        step(1, pl_t'(7), 1, pl_t'(8), 0, a0, a1);
        idle(3);
        check("t6_issued", 64'(op_c0[0]), 64'd1);
        apply_reset();
        check("t6_after_rdy1", 64'(rdy_c1), 64'd1);
        src0.push_back(pl_t'(9));
        src1.push_back(pl_t'(10));
        stream(0, 100);

`ifdef OPJOIN_WATCHDOG_EN
        // Watchdog abort and sticky err
        step(1, pl_t'(31), 1, pl_t'(32), 0, a0, a1);
        idle(20);
        check("t7_err_set", 64'(err), 64'd1);
        src0.push_back(pl_t'(33));
        src1.push_back(pl_t'(34));
        stream(0, 200);
        check("t7_err_sticky", 64'(err), 64'd1);
        apply_reset();
        check("t7_err_clear", 64'(err), 64'd0);
`else
        check("t7_err_tied", 64'(err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
